fu_delay_pipe: RTL and testbench
================================

Name: fu_delay_pipe

Overview:
- Parametrised successor to the single-lane late-ALU unit in the MEM stage.
- Accepts up to LANES instructions per cycle whose ALU result was deferred (Tnew==1 at MEM). Computes the result and applies the MOVN/MOVZ write-enable rule.
- Carries the register-write descriptor through a DEPTH-stage registered pipe with per-stage Tnew countdown.
- Exposes every in-flight stage to the hazard/bypass unit, with stall and flush.

Parameters:
- LANES, 2, issue width (1..4); lane 0 is the older instruction.
- DEPTH, 1, registered stages between input and out_* (1..3).
- TNEW_W, 2, width of the Tnew field.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- stall  in  1  hold all stages (back-pressure from WB)
- flush  in  1  kill all in-flight entries and the current input
- in_ready  out  1  = !stall
- in_valid  in  LANES  per-lane instruction valid
- in_alu_en  in  LANES  lane uses the late ALU
- in_alu_op  in  4*LANES  op code (fu_pkg encoding)
- in_src_a  in  LANES  operand A = zero-extended shamt instead of reg1
- in_src_b  in  LANES  operand B = immediate instead of reg2
- in_sign_b  in  LANES  immediate is extimm (1) or {16'h0, extimm[15:0]} (0)
- in_shamt  in  5*LANES  shift amount
- in_extimm  in  32*LANES  sign-extended immediate
- in_reg1, in_reg2  in  32*LANES  forwarded register operands
- in_wd_addr  in  5*LANES  destination register
- in_wd_data  in  32*LANES  data already produced upstream
- in_wd_tnew  in  TNEW_W*LANES  cycles until data ready
- out_valid  out  LANES  final-stage valid
- out_wd_addr / out_wd_data / out_wd_tnew  out  5/32/TNEW_W *LANES  final-stage descriptor
- fwd_addr / fwd_data / fwd_tnew  out  (5/32/TNEW_W)*LANES*DEPTH  every stage, stage-major; addr 0 when the entry is invalid

Behaviour:
- Reset: all stage valids 0; descriptors 0; all outputs 0 except in_ready = 1 when stall = 0.
- Stage 0 write descriptor, combinational per lane:
  - !alu_en: pass the input unchanged.
  - alu_en, tnew==1: data = ALU result.
  - alu_en, tnew!=1: data passes through.
  - Addr and tnew always pass through.
- Operand muxing:
  - a = src_a ? {27'h0, shamt} : reg1
  - b = src_b ? (sign_b ? extimm : zero-extended imm16) : reg2
- Ops:
  - Arithmetic/logic: ADD, SUB (wrap, no overflow trap), AND, OR, XOR, NOR, SLT (signed), SLTU.
  - Shifts: SLL/SRL/SRA of b by a[4:0]. LUI = {b[15:0], 16'h0}.
  - Conditional move: MOVN writes a when b!=0; MOVZ writes a when b==0.
  - CLO/CLZ: see Optional Feature.
- Write suppression: MOVN/MOVZ with a false condition forces the whole descriptor to 0 (addr 0 = no write); valid stays 1.
- Advance: when !stall, stage k+1 <= stage k and stage 0 <= the computed input.
  - tnew decrements by 1 per advance, saturating at 0.
  - When stall = 1, all stages hold and in_valid is ignored; the upstream stage must hold its input.
- Flush: synchronous, clears all stage valids and descriptor addrs. It beats stall and the current input, so flushed data never reaches out_valid.
- Lane ordering is preserved per stage. No inter-lane bypass inside the block: lane 1 operands are supplied already forwarded.
- Latency: exactly DEPTH cycles from an accepted input to out_*, excluding stall cycles.
- Reset asserted mid-operation clears everything immediately (async); the first accept after deassertion behaves as after power-up.

Optional Feature:
- Macro: FU_DELAY_CLO_CLZ_EN.
- Defined: CLO returns the count of leading ones of a, CLZ the count of leading zeros (0..32).
- Undefined: CLO/CLZ produce result 32'h0 with a normal write, and no count logic is synthesised.

Decomposition:
- fu_pkg holds:
  - ALU op localparams: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10, LUI=11, MOVN=12, MOVZ=13, CLO=14, CLZ=15.
  - Typedef wr_reg_info {addr[4:0], data[31:0], tnew[TNEW_W-1:0]}.
  - Per-lane input bundle typedef.
- Sub-module fu_delay_alu: purely combinational, one instance per lane, outputs result and write_reg. The pipe/stall/flush logic stays in fu_delay_pipe.

Test Plan:
- LANES=2, DEPTH=1: lane0 ADD reg1=5, reg2=7, tnew=1, addr=3 -> after 1 cycle out_valid=01, out_wd_data=12, addr=3, tnew=0.
- MOVZ a=32'hAA, b=1, addr=4 -> out_valid=1, descriptor all 0. Same op with b=0 -> data=32'hAA, addr=4.
- alu_en=0, data=32'h1234, tnew=2 -> out data=32'h1234, tnew=1. alu_en=1 with tnew=2 -> data still 32'h1234 (pass through).
- DEPTH=3: accept SLL b=1, shamt=4; stall for 2 cycles mid-flight -> out appears at cycle 5 with data 16. fwd_tnew shows 0 in stages 1-2, saturated.
- Flush asserted with stall=1 and 3 entries in flight -> next cycle all fwd_addr=0 and out_valid=0. resetn pulsed low mid-flight -> all outputs 0 asynchronously.
- CLZ a=32'h0000_8000: with FU_DELAY_CLO_CLZ_EN -> 16, CLO a=32'hFFFF_FFFF -> 32. Without the macro -> 0 for both.

Source files
------------

// File: rtl/fu_pkg.sv
// Shared definitions for the late-ALU delay pipe: op encodings, descriptor types and
// the leading-bit counter used by CLO/CLZ when FU_DELAY_CLO_CLZ_EN is defined.
package fu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MOVN = 4'd12;
  localparam logic [3:0] ALU_MOVZ = 4'd13;
  localparam logic [3:0] ALU_CLO  = 4'd14;
  localparam logic [3:0] ALU_CLZ  = 4'd15;

  // Tnew width carried through the ALU descriptor; the pipe's TNEW_W must not exceed it.
  localparam int FU_TNEW_W = 2;

  typedef struct packed {
    logic [4:0]           addr;
    logic [31:0]          data;
    logic [FU_TNEW_W-1:0] tnew;
  } wr_reg_info;

  typedef struct packed {
    logic        alu_en;
    logic [3:0]  alu_op;
    logic        src_a;
    logic        src_b;
    logic        sign_b;
    logic [4:0]  shamt;
    logic [31:0] extimm;
    logic [31:0] reg1;
    logic [31:0] reg2;
    wr_reg_info  wr;
  } lane_in_t;

  function automatic logic [31:0] count_leading(input logic [31:0] v, input logic bit_val);
    logic [31:0] n;
    logic        done;
    n    = '0;
    done = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!done) begin
        if (v[i] == bit_val) n = n + 32'd1;
        else                 done = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fu_delay_alu.sv
// Combinational late ALU for one lane: operand muxing, op evaluation and the MOVN/MOVZ
// write rule. CLO/CLZ counting exists only when FU_DELAY_CLO_CLZ_EN is defined.
module fu_delay_alu
  import fu_pkg::*;
(
  input  lane_in_t    lane,
  output logic [31:0] result,
  output logic        result_sel,
  output wr_reg_info  write_reg
);

  logic [31:0] a;
  logic [31:0] b;
  logic        move_ok;
  logic        compute_here;

  always_comb begin
    a = lane.src_a ? {27'h0, lane.shamt} : lane.reg1;
    if (lane.src_b) b = lane.sign_b ? lane.extimm : {16'h0, lane.extimm[15:0]};
    else            b = lane.reg2;
  end

  always_comb begin
    result  = '0;
    move_ok = 1'b1;
    case (lane.alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLL:  result = b << a[4:0];
      ALU_SRL:  result = b >> a[4:0];
      ALU_SRA:  result = $unsigned($signed(b) >>> a[4:0]);
      ALU_SLT:  result = {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'h0, a < b};
      ALU_LUI:  result = {b[15:0], 16'h0};
      ALU_MOVN: begin
        result  = a;
        move_ok = (b != 32'h0);
      end
      ALU_MOVZ: begin
        result  = a;
        move_ok = (b == 32'h0);
      end
`ifdef FU_DELAY_CLO_CLZ_EN
      ALU_CLO:  result = count_leading(a, 1'b1);
      ALU_CLZ:  result = count_leading(a, 1'b0);
`endif
      default:  result = '0;
    endcase
  end

  // Only entries whose data is due now (Tnew==1) take the ALU result or get suppressed.
  always_comb begin
    compute_here = lane.alu_en && (lane.wr.tnew == FU_TNEW_W'(1));
    result_sel   = compute_here && move_ok;
    write_reg    = lane.wr;
    if (compute_here && !move_ok) write_reg = '0;
  end

endmodule

// File: rtl/fu_delay_pipe.sv
// Multi-lane late-ALU delay pipe with per-stage Tnew countdown, stall, flush and
// per-stage forwarding taps. Optional CLO/CLZ via FU_DELAY_CLO_CLZ_EN.
module fu_delay_pipe
  import fu_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DEPTH  = 1,
  parameter int TNEW_W = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            stall,
  input  logic                            flush,
  output logic                            in_ready,
  input  logic [LANES-1:0]                in_valid,
  input  logic [LANES-1:0]                in_alu_en,
  input  logic [4*LANES-1:0]              in_alu_op,
  input  logic [LANES-1:0]                in_src_a,
  input  logic [LANES-1:0]                in_src_b,
  input  logic [LANES-1:0]                in_sign_b,
  input  logic [5*LANES-1:0]              in_shamt,
  input  logic [32*LANES-1:0]             in_extimm,
  input  logic [32*LANES-1:0]             in_reg1,
  input  logic [32*LANES-1:0]             in_reg2,
  input  logic [5*LANES-1:0]              in_wd_addr,
  input  logic [32*LANES-1:0]             in_wd_data,
  input  logic [TNEW_W*LANES-1:0]         in_wd_tnew,
  output logic [LANES-1:0]                out_valid,
  output logic [5*LANES-1:0]              out_wd_addr,
  output logic [32*LANES-1:0]             out_wd_data,
  output logic [TNEW_W*LANES-1:0]         out_wd_tnew,
  output logic [5*LANES*DEPTH-1:0]        fwd_addr,
  output logic [32*LANES*DEPTH-1:0]       fwd_data,
  output logic [TNEW_W*LANES*DEPTH-1:0]   fwd_tnew
);

  logic [DEPTH-1:0][LANES-1:0]              stg_valid;
  logic [DEPTH-1:0][LANES-1:0][4:0]         stg_addr;
  logic [DEPTH-1:0][LANES-1:0][31:0]        stg_data;
  logic [DEPTH-1:0][LANES-1:0][TNEW_W-1:0]  stg_tnew;

  logic [LANES-1:0][4:0]        nxt_addr;
  logic [LANES-1:0][31:0]       nxt_data;
  logic [LANES-1:0][TNEW_W-1:0] nxt_tnew;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_in_t    lane;
    wr_reg_info  wr;
    logic [31:0] res;
    logic        sel;

    assign lane.alu_en  = in_alu_en[l];
    assign lane.alu_op  = in_alu_op[l*4 +: 4];
    assign lane.src_a   = in_src_a[l];
    assign lane.src_b   = in_src_b[l];
    assign lane.sign_b  = in_sign_b[l];
    assign lane.shamt   = in_shamt[l*5 +: 5];
    assign lane.extimm  = in_extimm[l*32 +: 32];
    assign lane.reg1    = in_reg1[l*32 +: 32];
    assign lane.reg2    = in_reg2[l*32 +: 32];
    assign lane.wr.addr = in_wd_addr[l*5 +: 5];
    assign lane.wr.data = in_wd_data[l*32 +: 32];
    assign lane.wr.tnew = FU_TNEW_W'(in_wd_tnew[l*TNEW_W +: TNEW_W]);

    fu_delay_alu u_alu (
      .lane       (lane),
      .result     (res),
      .result_sel (sel),
      .write_reg  (wr)
    );

    // Invalid lanes load an all-zero descriptor so stale fields never reach out_*.
    assign nxt_addr[l] = in_valid[l] ? wr.addr : '0;
    assign nxt_data[l] = in_valid[l] ? (sel ? res : wr.data) : '0;
    assign nxt_tnew[l] = in_valid[l] ? tnew_dec(TNEW_W'(wr.tnew)) : '0;
  end

  // Flush wins over stall and the current input; stall freezes every stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stg_valid <= '0;
      stg_addr  <= '0;
      stg_data  <= '0;
      stg_tnew  <= '0;
    end else if (flush) begin
      stg_valid <= '0;
      stg_addr  <= '0;
    end else if (!stall) begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        stg_valid[s] <= stg_valid[s-1];
        stg_addr[s]  <= stg_addr[s-1];
        stg_data[s]  <= stg_data[s-1];
        for (int l = 0; l < LANES; l++) begin
          stg_tnew[s][l] <= tnew_dec(stg_tnew[s-1][l]);
        end
      end
      stg_valid[0] <= in_valid;
      stg_addr[0]  <= nxt_addr;
      stg_data[0]  <= nxt_data;
      stg_tnew[0]  <= nxt_tnew;
    end
  end

  assign in_ready    = !stall;
  assign out_valid   = stg_valid[DEPTH-1];
  assign out_wd_addr = stg_addr[DEPTH-1];
  assign out_wd_data = stg_data[DEPTH-1];
  assign out_wd_tnew = stg_tnew[DEPTH-1];
  assign fwd_data    = stg_data;
  assign fwd_tnew    = stg_tnew;

  always_comb begin
    fwd_addr = '0;
    for (int s = 0; s < DEPTH; s++) begin
      for (int l = 0; l < LANES; l++) begin
        fwd_addr[(s*LANES+l)*5 +: 5] = stg_valid[s][l] ? stg_addr[s][l] : 5'h0;
      end
    end
  end

endmodule

// File: tb/tb_fu_delay_pipe.sv
// Directed self-checking bench for fu_delay_pipe: a DEPTH=1 and a DEPTH=3 instance
// (LANES=2) share one stimulus stream. Expectations follow FU_DELAY_CLO_CLZ_EN.
module tb_fu_delay_pipe;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        flush;
  logic [1:0]  in_valid, in_alu_en, in_src_a, in_src_b, in_sign_b;
  logic [7:0]  in_alu_op;
  logic [9:0]  in_shamt, in_wd_addr;
  logic [63:0] in_extimm, in_reg1, in_reg2, in_wd_data;
  logic [3:0]  in_wd_tnew;

  logic        d1_in_ready, d3_in_ready;
  logic [1:0]  d1_out_valid, d3_out_valid;
  logic [9:0]  d1_out_wd_addr, d3_out_wd_addr;
  logic [63:0] d1_out_wd_data, d3_out_wd_data;
  logic [3:0]  d1_out_wd_tnew, d3_out_wd_tnew;
  logic [9:0]  d1_fwd_addr;
  logic [63:0] d1_fwd_data;
  logic [3:0]  d1_fwd_tnew;
  logic [29:0] d3_fwd_addr;
  logic [191:0] d3_fwd_data;
  logic [11:0] d3_fwd_tnew;

  int testsRun  = 0;
  int failCount = 0;

  fu_delay_pipe #(.LANES(2), .DEPTH(1), .TNEW_W(2)) dut1 (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush), .in_ready(d1_in_ready),
    .in_valid(in_valid), .in_alu_en(in_alu_en), .in_alu_op(in_alu_op),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_sign_b(in_sign_b),
    .in_shamt(in_shamt), .in_extimm(in_extimm), .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_wd_addr(in_wd_addr), .in_wd_data(in_wd_data), .in_wd_tnew(in_wd_tnew),
    .out_valid(d1_out_valid), .out_wd_addr(d1_out_wd_addr), .out_wd_data(d1_out_wd_data),
    .out_wd_tnew(d1_out_wd_tnew), .fwd_addr(d1_fwd_addr), .fwd_data(d1_fwd_data),
    .fwd_tnew(d1_fwd_tnew)
  );

  fu_delay_pipe #(.LANES(2), .DEPTH(3), .TNEW_W(2)) dut3 (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush), .in_ready(d3_in_ready),
    .in_valid(in_valid), .in_alu_en(in_alu_en), .in_alu_op(in_alu_op),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_sign_b(in_sign_b),
    .in_shamt(in_shamt), .in_extimm(in_extimm), .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_wd_addr(in_wd_addr), .in_wd_data(in_wd_data), .in_wd_tnew(in_wd_tnew),
    .out_valid(d3_out_valid), .out_wd_addr(d3_out_wd_addr), .out_wd_data(d3_out_wd_data),
    .out_wd_tnew(d3_out_wd_tnew), .fwd_addr(d3_fwd_addr), .fwd_data(d3_fwd_data),
    .fwd_tnew(d3_fwd_tnew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clearInputs();
    in_valid = '0; in_alu_en = '0; in_alu_op = '0; in_src_a = '0; in_src_b = '0;
    in_sign_b = '0; in_shamt = '0; in_extimm = '0; in_reg1 = '0; in_reg2 = '0;
    in_wd_addr = '0; in_wd_data = '0; in_wd_tnew = '0;
  endtask

  // Clears all lanes, then drives one valid instruction on the given lane.
  task automatic applyStimulus(input int lane, input logic alu_en, input logic [3:0] op,
                               input logic src_a, input logic src_b, input logic sign_b,
                               input logic [4:0] shamt, input logic [31:0] extimm,
                               input logic [31:0] reg1, input logic [31:0] reg2,
                               input logic [4:0] addr, input logic [31:0] data,
                               input logic [1:0] tnew);
    clearInputs();
    in_valid[lane]            = 1'b1;
    in_alu_en[lane]           = alu_en;
    in_alu_op[lane*4 +: 4]    = op;
    in_src_a[lane]            = src_a;
    in_src_b[lane]            = src_b;
    in_sign_b[lane]           = sign_b;
    in_shamt[lane*5 +: 5]     = shamt;
    in_extimm[lane*32 +: 32]  = extimm;
    in_reg1[lane*32 +: 32]    = reg1;
    in_reg2[lane*32 +: 32]    = reg2;
    in_wd_addr[lane*5 +: 5]   = addr;
    in_wd_data[lane*32 +: 32] = data;
    in_wd_tnew[lane*2 +: 2]   = tnew;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle check of lane 0 on the DEPTH=1 instance.
  task automatic checkLane0(input string tag, input logic [4:0] addr, input logic [31:0] data,
                            input logic [1:0] tnew);
    checkOutput({tag, "_valid"}, 64'(d1_out_valid), 64'h1);
    checkOutput({tag, "_addr"}, 64'(d1_out_wd_addr[4:0]), 64'(addr));
    checkOutput({tag, "_data"}, 64'(d1_out_wd_data[31:0]), 64'(data));
    checkOutput({tag, "_tnew"}, 64'(d1_out_wd_tnew[1:0]), 64'(tnew));
  endtask

  initial begin
    clearInputs();
    stall  = 1'b0;
    flush  = 1'b0;
    resetn = 1'b0;
    #12;
    checkOutput("rst_valid", 64'(d1_out_valid), 64'h0);
    checkOutput("rst_data", d1_out_wd_data, 64'h0);
    checkOutput("rst_fwd3", 64'(d3_fwd_addr), 64'h0);
    checkOutput("rst_ready", 64'(d1_in_ready), 64'h1);
    tick();
    resetn = 1'b1;

    applyStimulus(0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7, 5'd3, 32'h0, 2'd1);
    tick();
    checkLane0("add", 5'd3, 32'd12, 2'd0);
    checkOutput("add_d3_fwd0", 64'(d3_fwd_addr[4:0]), 64'd3);

    applyStimulus(0, 1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'hAA, 32'd1, 5'd4, 32'h0, 2'd1);
    tick();
    checkLane0("movz_false", 5'd0, 32'h0, 2'd0);
    checkOutput("add_d3_fwd1", 64'(d3_fwd_addr[14:10]), 64'd3);

    applyStimulus(0, 1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'hAA, 32'd0, 5'd4, 32'h0, 2'd1);
    tick();
    checkLane0("movz_true", 5'd4, 32'hAA, 2'd0);

    applyStimulus(0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7, 5'd5, 32'h1234, 2'd2);
    tick();
    checkLane0("noalu", 5'd5, 32'h1234, 2'd1);

    applyStimulus(0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7, 5'd5, 32'h1234, 2'd2);
    tick();
    checkLane0("tnew2", 5'd5, 32'h1234, 2'd1);

    applyStimulus(0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd3, 32'd5, 5'd6, 32'h0, 2'd1);
    tick();
    checkLane0("sub", 5'd6, 32'hFFFF_FFFE, 2'd0);

    applyStimulus(0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0, 32'h0, 32'h8000_0000, 5'd6, 32'h0, 2'd1);
    tick();
    checkLane0("sra", 5'd6, 32'hF800_0000, 2'd0);

    applyStimulus(0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'h0, 2'd1);
    tick();
    checkLane0("slt", 5'd6, 32'd1, 2'd0);

    applyStimulus(0, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'h0, 2'd1);
    tick();
    checkLane0("sltu", 5'd6, 32'd0, 2'd0);

    applyStimulus(0, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_1234, 32'h0, 32'h0, 5'd6, 32'h0, 2'd1);
    tick();
    checkLane0("lui", 5'd6, 32'h1234_0000, 2'd0);

    applyStimulus(0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd6, 32'h0, 2'd1);
    tick();
    checkLane0("addi_sx", 5'd6, 32'hFFFF_FFFF, 2'd0);

    applyStimulus(1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'hF0, 32'h0F, 5'd7, 32'h0, 2'd1);
    tick();
    checkOutput("lane1_valid", 64'(d1_out_valid), 64'h2);
    checkOutput("lane1_data", d1_out_wd_data, {32'hFF, 32'h0});
    checkOutput("lane1_addr", 64'(d1_out_wd_addr), {54'h0, 5'd7, 5'd0});

    // Drain the DEPTH=3 instance, then run SLL through it with a 2-cycle stall.
    clearInputs();
    tick(); tick(); tick();
    checkOutput("drain_d3", 64'(d3_out_valid), 64'h0);
    applyStimulus(0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 5'd4, 32'h1, 32'h0, 32'h0, 5'd9, 32'h0, 2'd1);
    tick();
    clearInputs();
    checkOutput("sll_s0_addr", 64'(d3_fwd_addr[4:0]), 64'd9);
    tick();
    checkOutput("sll_s1_addr", 64'(d3_fwd_addr[14:10]), 64'd9);
    stall = 1'b1;
    applyStimulus(0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd11, 32'h77, 2'd1);
    tick();
    checkOutput("stall_ready", 64'(d3_in_ready), 64'h0);
    checkOutput("stall_out", 64'(d3_out_valid), 64'h0);
    tick();
    clearInputs();
    stall = 1'b0;
    checkOutput("stall_s0_ignored", 64'(d3_fwd_addr[4:0]), 64'd0);
    checkOutput("stall_s1_hold", 64'(d3_fwd_addr[14:10]), 64'd9);
    tick();
    checkOutput("sll_out_valid", 64'(d3_out_valid), 64'h1);
    checkOutput("sll_out_data", 64'(d3_out_wd_data[31:0]), 64'd16);
    checkOutput("sll_out_tnew", 64'(d3_out_wd_tnew[1:0]), 64'd0);
    checkOutput("sll_fwd_tnew", 64'(d3_fwd_tnew), 64'h0);

    // Fill three stages, then flush under stall with a new input pending.
    applyStimulus(0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd1, 32'h11, 2'd2);
    tick();
    applyStimulus(0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd2, 32'h22, 2'd2);
    tick();
    applyStimulus(0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 32'h33, 2'd2);
    tick();
    checkOutput("fill_fwd", 64'(d3_fwd_addr), 64'({5'd0, 5'd1, 5'd0, 5'd2, 5'd0, 5'd3}));
    checkOutput("fill_tnew", 64'(d3_fwd_tnew), 64'({2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1}));
    checkOutput("fill_out_data", 64'(d3_out_wd_data[31:0]), 64'h11);
    stall = 1'b1;
    flush = 1'b1;
    applyStimulus(0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd12, 32'h44, 2'd1);
    tick();
    stall = 1'b0;
    flush = 1'b0;
    clearInputs();
    checkOutput("flush_fwd3", 64'(d3_fwd_addr), 64'h0);
    checkOutput("flush_out3", 64'(d3_out_valid), 64'h0);
    checkOutput("flush_out1", 64'(d1_out_valid), 64'h0);
    checkOutput("flush_addr1", 64'(d1_out_wd_addr), 64'h0);
    tick();
    checkOutput("flush_no_leak", 64'(d1_out_valid), 64'h0);

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd6, 32'h55, 2'd1);
    tick();
    checkOutput("pre_rst_valid", 64'(d1_out_valid), 64'h1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("arst_valid1", 64'(d1_out_valid), 64'h0);
    checkOutput("arst_data1", d1_out_wd_data, 64'h0);
    checkOutput("arst_fwd3", 64'(d3_fwd_addr), 64'h0);
    checkOutput("arst_tnew3", 64'(d3_fwd_tnew), 64'h0);
    tick();
    resetn = 1'b1;
    applyStimulus(0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd1, 32'd2, 5'd10, 32'h0, 2'd1);
    tick();
    checkLane0("post_rst_add", 5'd10, 32'd3, 2'd0);

    applyStimulus(0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_8000, 32'h0, 5'd8, 32'h0, 2'd1);
    tick();
`ifdef FU_DELAY_CLO_CLZ_EN
    checkLane0("clz", 5'd8, 32'd16, 2'd0);
`else
    checkLane0("clz", 5'd8, 32'd0, 2'd0);
`endif
    applyStimulus(0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd8, 32'h0, 2'd1);
    tick();
`ifdef FU_DELAY_CLO_CLZ_EN
    checkLane0("clo", 5'd8, 32'd32, 2'd0);
`else
    checkLane0("clo", 5'd8, 32'd0, 2'd0);
`endif

    clearInputs();
    tick();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
